imem_fetch_server: RTL and testbench
====================================

// Module: imem_fetch_server
// PURPOSE
//  Instruction-memory responder for the pipelined core: serves 32-bit instruction words for
//  byte-addressed PC fetch requests with fixed pipelined latency, in-order responses, backpressure
//  and flush. Sits between IF stage (requester) and a preloadable word memory (bench/loader).
// PARAMETERS
//  DEPTH    1024  instruction words stored; AW = $clog2(DEPTH)
//  LATENCY  2     cycles from request accept to earliest response (legal 1..4)
//  OUT_MAX  4     max outstanding requests (in pipeline + output FIFO); output FIFO depth = OUT_MAX
// PORTS
//  clk        in   1   rising-edge clock
//  reset_n    in   1   asynchronous, active-low reset
//  wr_en      in   1   preload write strobe
//  wr_addr    in   AW  preload word index
//  wr_data    in   32  preload instruction word
//  req_valid  in   1   fetch request valid
//  req_ready  out  1   fetch request accepted when req_valid && req_ready
//  req_pc     in   64  byte address of instruction
//  flush      in   1   discard all in-flight and buffered responses (branch redirect)
//  rsp_valid  out  1   response available (FIFO head)
//  rsp_ready  in   1   consumer pops head when rsp_valid && rsp_ready
//  rsp_instr  out  32  instruction word
//  rsp_pc     out  64  PC of the request this response answers
//  rsp_err    out  1   1 = misaligned or out-of-range PC; rsp_instr then 32'h00000013 (NOP)
// BEHAVIOUR
//  - Reset (reset_n=0, async): all pipeline valids, FIFO pointers, outstanding count cleared;
//    req_ready=0, rsp_valid=0, rsp_instr=0, rsp_pc=0, rsp_err=0. Memory array NOT reset.
//  - Memory: wr_en writes mem[wr_addr] at posedge. Read occurs at request accept, read-before-write:
//    same-cycle write to the fetched word returns the OLD word; the new word visible next cycle.
//  - Decode at accept: err = (req_pc[1:0]!=0) || (req_pc[63:2] >= DEPTH); else instr = mem[req_pc[AW+1:2]].
//  - Pipeline: LATENCY stages {valid, pc, instr, err}; request accepted in cycle N is pushed to FIFO
//    at end of cycle N+LATENCY-1, so rsp_valid is high in cycle N+LATENCY if FIFO was empty.
//  - Responses strictly in request order; rsp_* hold stable while rsp_valid && !rsp_ready.
//  - Outstanding count: +1 on accept, -1 on pop; both in same cycle -> unchanged. Range 0..OUT_MAX.
//  - req_ready = reset_n && !flush && (outstanding < OUT_MAX). Guarantees FIFO never overflows;
//    pipeline never stalls (FIFO space pre-reserved by credit).
//  - Back-to-back: with rsp_ready=1 and OUT_MAX >= LATENCY+1, one accept per cycle sustained.
//  - flush=1 (single cycle, takes effect at posedge): all stage valids and FIFO cleared, count=0;
//    no request accepted that cycle (req_ready=0); a pop in the flush cycle is still honoured by
//    consumer but irrelevant (FIFO empties). rsp_valid=0 the cycle after flush.
//  - flush and reset_n both asserted: reset wins.
//  - Reset mid-operation: everything in flight lost; req_ready=1 from first posedge after release.
//  - FIFO pointers wrap modulo OUT_MAX; full/empty via count, not pointer compare.
// TESTING
//  1 Preload mem[0..3]=A,B,C,D; LATENCY=2; req PC 0,4,8,12 back-to-back, rsp_ready=1 -> rsp A,B,C,D
//    in cycles N+2..N+5, rsp_pc 0,4,8,12, rsp_err=0, req_ready stays 1.
//  2 rsp_ready=0, req_valid=1 continuous -> exactly 4 accepts then req_ready=0; raise rsp_ready ->
//    4 responses drained in order, req_ready=1 again the cycle after first pop.
//  3 req PC 0x6 -> rsp_err=1, rsp_instr=32'h00000013; PC 0x1000 (DEPTH=1024) -> rsp_err=1, NOP.
//  4 3 requests in flight, pulse flush -> none of them returned, req_ready=0 during flush;
//    next req PC 0x28 -> rsp_instr=mem[10] exactly 2 cycles after accept.
//  5 wr_en to mem[5]=X while fetching PC 0x14 same cycle -> old value; refetch next cycle -> X.
//  6 Drop reset_n mid-traffic (async, between edges) -> rsp_valid/req_ready 0 immediately; after
//    release mem contents intact, fresh fetch of PC 0 returns A.

Source files
------------

// File: rtl/imem_fetch_server_if.sv
// Fetch-side bundle between the IF stage (master) and the instruction memory
// responder (slave): preload write port, request channel, flush and the
// response channel.
interface imem_fetch_server_if #(
  parameter int AW = 10
);
  // Preload port (bench / loader)
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  // Fetch request channel
  logic          req_valid;
  logic          req_ready;
  logic [63:0]   req_pc;

  // Branch redirect: drop everything in flight
  logic          flush;

  // Response channel (head of the in-order response FIFO)
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_instr;
  logic [63:0]   rsp_pc;
  logic          rsp_err;

  modport master (
    output wr_en, wr_addr, wr_data,
    output req_valid, req_pc, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  req_valid, req_pc, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_err
  );
endinterface

// File: rtl/imem_fetch_server.sv
// Instruction-memory responder. Accepted fetches read the word array at the
// accept edge, ride a fixed-length pipeline and land in an in-order response
// FIFO. Credit counting (outstanding requests) reserves FIFO space up front,
// so the pipeline never has to stall. Flush drops pipeline and FIFO contents.
module imem_fetch_server #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int OUT_MAX = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  imem_fetch_server_if.slave  bus
);

  localparam int AW   = $clog2(DEPTH);
  // Register stages in front of the FIFO; the FIFO write is the final stage.
  localparam int NREG = (LATENCY > 1) ? LATENCY - 1 : 1;
  localparam int PW   = (OUT_MAX > 1) ? $clog2(OUT_MAX) : 1;
  localparam int CW   = $clog2(OUT_MAX + 1);

  localparam logic [31:0]   NOP_INSTR = 32'h0000_0013;
  localparam logic [CW-1:0] OUT_LIMIT = CW'(OUT_MAX);
  localparam logic [PW-1:0] PTR_LAST  = PW'(OUT_MAX - 1);

  // Instruction word storage (never reset; contents survive reset_n)
  logic [31:0] mem [DEPTH];

  // Request decode
  logic          req_ready;
  logic          accept;
  logic          req_err;
  logic [AW-1:0] req_idx;

  // Stage feeding the FIFO
  logic          push_valid;
  logic [63:0]   push_pc;
  logic [31:0]   push_raw;
  logic          push_err;

  // Response FIFO
  logic [63:0]   fifo_pc_q    [OUT_MAX];
  logic [31:0]   fifo_instr_q [OUT_MAX];
  logic          fifo_err_q   [OUT_MAX];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic          rsp_valid;
  logic          pop;

  // Outstanding-request credit counter
  logic [CW-1:0] out_cnt_q, out_cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Misaligned or beyond the last stored word answers with an error NOP.
  assign req_err   = (bus.req_pc[1:0] != 2'b00) || (bus.req_pc[63:2] >= 62'(DEPTH));
  assign req_idx   = bus.req_pc[AW+1:2];

  // No accepts while in reset, while flushing, or with every slot credited out.
  assign req_ready = reset_n && !bus.flush && (out_cnt_q < OUT_LIMIT);
  assign accept    = bus.req_valid && req_ready;

  assign rsp_valid = (fcnt_q != '0);
  assign pop       = rsp_valid && bus.rsp_ready;

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  // Zero the data outputs whenever nothing is presented (covers reset and flush).
  assign bus.rsp_instr = rsp_valid ? fifo_instr_q[rptr_q] : '0;
  assign bus.rsp_pc    = rsp_valid ? fifo_pc_q[rptr_q]    : '0;
  assign bus.rsp_err   = rsp_valid ? fifo_err_q[rptr_q]   : 1'b0;

  // Preload write; a same-edge read sees the old word because reads are registered.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  generate
    if (LATENCY > 1) begin : g_pipe
      logic        st_valid_q [NREG];
      logic [63:0] st_pc_q    [NREG];
      logic [31:0] st_instr_q [NREG];
      logic        st_err_q   [NREG];

      // Stage valids: cleared by reset or flush, otherwise shift one per cycle.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int k = 0; k < NREG; k++) st_valid_q[k] <= 1'b0;
        end else if (bus.flush) begin
          for (int k = 0; k < NREG; k++) st_valid_q[k] <= 1'b0;
        end else begin
          st_valid_q[0] <= accept;
          for (int k = 1; k < NREG; k++) st_valid_q[k] <= st_valid_q[k-1];
        end
      end

      // Stage payload: memory read at the accept edge, then plain shifting.
      always_ff @(posedge clk) begin
        st_pc_q[0]    <= bus.req_pc;
        st_err_q[0]   <= req_err;
        st_instr_q[0] <= mem[req_idx];
        for (int k = 1; k < NREG; k++) begin
          st_pc_q[k]    <= st_pc_q[k-1];
          st_err_q[k]   <= st_err_q[k-1];
          st_instr_q[k] <= st_instr_q[k-1];
        end
      end

      assign push_valid = st_valid_q[NREG-1];
      assign push_pc    = st_pc_q[NREG-1];
      assign push_raw   = st_instr_q[NREG-1];
      assign push_err   = st_err_q[NREG-1];
    end else begin : g_direct
      // Single-cycle latency: the FIFO slot itself captures the memory read.
      assign push_valid = accept;
      assign push_pc    = bus.req_pc;
      assign push_raw   = mem[req_idx];
      assign push_err   = req_err;
    end
  endgenerate

  // Next-state for FIFO pointers, occupancy and the credit counter.
  always_comb begin
    out_cnt_d = out_cnt_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    fcnt_d    = fcnt_q;
    if (bus.flush) begin
      out_cnt_d = '0;
      wptr_d    = '0;
      rptr_d    = '0;
      fcnt_d    = '0;
    end else begin
      if (accept && !pop) begin
        out_cnt_d = out_cnt_q + CW'(1);
      end else if (!accept && pop) begin
        out_cnt_d = out_cnt_q - CW'(1);
      end
      if (push_valid) begin
        wptr_d = ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_d = ptr_inc(rptr_q);
      end
      if (push_valid && !pop) begin
        fcnt_d = fcnt_q + CW'(1);
      end else if (!push_valid && pop) begin
        fcnt_d = fcnt_q - CW'(1);
      end
    end
  end

  // Control state registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_cnt_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      fcnt_q    <= '0;
    end else begin
      out_cnt_q <= out_cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      fcnt_q    <= fcnt_d;
    end
  end

  // FIFO payload write; errored fetches are stored as NOP.
  always_ff @(posedge clk) begin
    if (push_valid && !bus.flush) begin
      fifo_pc_q[wptr_q]    <= push_pc;
      fifo_err_q[wptr_q]   <= push_err;
      fifo_instr_q[wptr_q] <= push_err ? NOP_INSTR : push_raw;
    end
  end

endmodule

// File: tb/tb_imem_fetch_server.sv
// Randomised and directed bench for imem_fetch_server. A queue of expected
// responses, each stamped with the earliest cycle it may appear, models the
// responder; a word array models memory contents.
module tb_imem_fetch_server;

  localparam int DEPTH   = 1024;
  localparam int LAT     = 2;
  localparam int OUT_MAX = 4;
  localparam int LOADED  = 64;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        err;
    int          rdy;
  } exp_t;

  logic clk;
  logic reset_n;

  imem_fetch_server_if #(.AW(10)) bus ();

  imem_fetch_server #(
    .DEPTH   (DEPTH),
    .LATENCY (LAT),
    .OUT_MAX (OUT_MAX)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem_model [DEPTH];
  exp_t        exp_q [$];
  int          cyc     = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model_fetch(input logic [63:0] pc);
    exp_t e;
    e.pc    = pc;
    e.err   = (pc % 4 != 0) || (pc >= 64'(DEPTH * 4));
    e.instr = e.err ? 32'h0000_0013 : mem_model[pc[11:2]];
    e.rdy   = 0;
    return e;
  endfunction

  // One clock cycle: drive, compare against the model, advance model at posedge.
  task automatic tick(input logic v, input logic [63:0] pc, input logic rr, input logic fl,
                      input logic we, input logic [9:0] wa, input logic [31:0] wd);
    exp_t e;
    logic exp_valid, exp_ready, acc, pop;
    bus.req_valid = v;
    bus.req_pc    = pc;
    bus.rsp_ready = rr;
    bus.flush     = fl;
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    #1;
    exp_valid = (exp_q.size() != 0) && (exp_q[0].rdy <= cyc);
    exp_ready = !fl && (exp_q.size() < OUT_MAX);
    check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_valid));
    check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    if (exp_valid) begin
      check("rsp_pc", bus.rsp_pc, exp_q[0].pc);
      check("rsp_instr", 64'(bus.rsp_instr), 64'(exp_q[0].instr));
      check("rsp_err", 64'(bus.rsp_err), 64'(exp_q[0].err));
    end
    acc = v && exp_ready;
    pop = exp_valid && rr;
    if (acc) e = model_fetch(pc);
    @(posedge clk);
    if (pop) begin
      $display("cycle %0d rsp pc=%h instr=%h err=%0d", cyc, exp_q[0].pc, exp_q[0].instr, exp_q[0].err);
      void'(exp_q.pop_front());
    end
    if (fl) begin
      exp_q.delete();
    end else if (acc) begin
      e.rdy = cyc + LAT;
      exp_q.push_back(e);
    end
    if (we) mem_model[wa] = wd;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    check({tag, "_rsp_instr"}, 64'(bus.rsp_instr), 64'd0);
    check({tag, "_rsp_pc"},    bus.rsp_pc,         64'd0);
    check({tag, "_rsp_err"},   64'(bus.rsp_err),   64'd0);
  endtask

  // Assert reset between clock edges, hold across a posedge, release on a negedge.
  task automatic async_reset();
    #2;
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.wr_en     = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] pc;
    logic [31:0] wd;
    int          r;

    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_pc    = '0;
    bus.rsp_ready = 1'b0;
    bus.flush     = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Preload: words 0..3 fixed, the rest of the loaded window random.
    for (int i = 0; i < LOADED; i++) begin
      case (i)
        0:       wd = 32'hAAAA_0001;
        1:       wd = 32'hBBBB_0002;
        2:       wd = 32'hCCCC_0003;
        3:       wd = 32'hDDDD_0004;
        default: wd = $urandom;
      endcase
      tick(1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 10'(i), wd);
    end

    // Back-to-back fetches of PC 0,4,8,12 with the consumer always ready.
    for (int i = 0; i < 4; i++) tick(1'b1, 64'(4 * i), 1'b1, 1'b0, 1'b0, 10'd0, 32'd0);
    idle(4);

    // Consumer stalled: credits run out after four accepts, then drain.
    for (int i = 0; i < 8; i++) tick(1'b1, 64'(4 * i), 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
    for (int i = 0; i < 8; i++) tick(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0);

    // Misaligned and out-of-range PCs.
    tick(1'b1, 64'h6,    1'b1, 1'b0, 1'b0, 10'd0, 32'd0);
    tick(1'b1, 64'h1000, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0);
    idle(4);

    // Three in flight, flush with a request pending, then refetch PC 0x28.
    for (int i = 0; i < 3; i++) tick(1'b1, 64'(16 + 4 * i), 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
    tick(1'b1, 64'h30, 1'b0, 1'b1, 1'b0, 10'd0, 32'd0);
    tick(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0);
    tick(1'b1, 64'h28, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0);
    idle(4);

    // Same-cycle write to the fetched word returns old data, next fetch sees new.
    tick(1'b1, 64'h14, 1'b1, 1'b0, 1'b1, 10'd5, 32'h5EED_F00D);
    tick(1'b1, 64'h14, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0);
    idle(4);

    // Reset dropped mid-traffic; memory survives, PC 0 still reads the first word.
    for (int i = 0; i < 3; i++) tick(1'b1, 64'(4 * i), 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
    async_reset();
    tick(1'b1, 64'd0, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0);
    tick(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0);
    check("rst_mem_intact", 64'(bus.rsp_instr), 64'h0000_0000_AAAA_0001);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 15);
      if (r == 0) begin
        pc = 64'(4 * $urandom_range(0, LOADED - 1) + $urandom_range(1, 3));
      end else if (r == 1) begin
        pc = ($urandom_range(0, 1) == 0) ? 64'(DEPTH * 4 + 4 * $urandom_range(0, 200))
                                         : {1'b1, 31'($urandom), 30'($urandom), 2'b00};
      end else begin
        pc = 64'(4 * $urandom_range(0, LOADED - 1));
      end
      tick($urandom_range(0, 3) != 0, pc, $urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0,
           10'($urandom_range(0, LOADED - 1)), $urandom);
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
